norm_shift_encoder: RTL and testbench

Parametrised normalisation-shift encoder for the pipelined floating-point adder. It takes the unnormalised mantissa sum, of width WIDTH, and produces the normalisation shift code. The code is either a one-position right shift (carry-out), a left-shift amount, or a zero-result marker. Inputs are priority-encoded, so a sum with several bits set still yields the correct shift. It sits between the mantissa adder and the normalising shifter, and carries a sideband tag so that exponent/sign context stays aligned with the code.

---
 rtl/norm_enc_pkg.sv | 13 +
 rtl/norm_shift_encoder_lzc_group.sv | 17 +
 rtl/norm_shift_encoder.sv | 167 ++++++++++++++++
 tb/tb_norm_shift_encoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/norm_enc_pkg.sv
// Shared constants and the stage-1 group record for the normalisation-shift encoder.
package norm_enc_pkg;

  localparam logic [7:0] CODE_SHR1 = 8'h80;
  localparam logic [7:0] CODE_ZERO = 8'h40;
  localparam int         GROUP_W   = 16;

  typedef struct packed {
    logic       nz;
    logic [3:0] lz;
  } grp_t;

endpackage

// File: rtl/norm_shift_encoder_lzc_group.sv
// lzc_group: combinational 16-bit leading-zero counter (nonzero flag + 4-bit count).
module lzc_group (
  input  logic [15:0] din,
  output logic        nonzero,
  output logic [3:0]  lz
);

  always_comb begin
    nonzero = |din;
    lz      = 4'd0;
    // Ascending scan: the highest set bit is the last one to write lz.
    for (int i = 0; i < 16; i++) begin
      if (din[i]) lz = 4'(15 - i);
    end
  end

endmodule

// File: rtl/norm_shift_encoder.sv
// Normalisation-shift encoder: priority-encodes the mantissa sum into a shift code.
// Optional NORM_ENC_IN_REG_EN adds an input register stage ahead of stage 1.
module norm_shift_encoder
  import norm_enc_pkg::*;
#(
  parameter int WIDTH   = 49,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  output logic [7:0]       out_code,
  output logic             shift_right,
  output logic             zero,
  output logic [5:0]       shl_amt,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NG  = (WIDTH - 1 + GROUP_W - 1) / GROUP_W;
  localparam int PW  = NG * GROUP_W;
  localparam int PAD = PW - (WIDTH - 1);

  if (WIDTH < 4 || WIDTH > 65) begin : g_bad_width
    $error("norm_shift_encoder: WIDTH must be 4..65");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("norm_shift_encoder: LATENCY must be 1 or 2");
  end

  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic [TAG_W-1:0] s_tag;

`ifdef NORM_ENC_IN_REG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_tag   <= '0;
    end else begin
      s_valid <= valid_in & ~flush;
      if (valid_in && !flush) begin
        s_data <= in_data;
        s_tag  <= tag_in;
      end
    end
  end
`else
  assign s_valid = valid_in;
  assign s_data  = in_data;
  assign s_tag   = tag_in;
`endif

  // Non-carry bits, MSB-aligned into whole groups; the lowest group is zero-padded.
  logic [PW-1:0]     padded;
  grp_t [NG-1:0]     grp_c;

  assign padded = PW'(s_data[WIDTH-2:0]) << PAD;

  for (genvar g = 0; g < NG; g++) begin : g_lzc
    logic       nz_w;
    logic [3:0] lz_w;
    lzc_group u_lzc (
      .din     (padded[PW-1-g*GROUP_W -: GROUP_W]),
      .nonzero (nz_w),
      .lz      (lz_w)
    );
    assign grp_c[g] = {nz_w, lz_w};
  end

  logic             e_valid;
  logic             e_carry;
  grp_t [NG-1:0]    e_grp;
  logic [TAG_W-1:0] e_tag;

  if (LATENCY == 2) begin : g_stage1
    logic             s1_valid;
    logic             s1_carry;
    grp_t [NG-1:0]    s1_grp;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1_valid <= 1'b0;
        s1_carry <= 1'b0;
        s1_grp   <= '0;
        s1_tag   <= '0;
      end else begin
        s1_valid <= s_valid & ~flush;
        if (s_valid && !flush) begin
          s1_carry <= s_data[WIDTH-1];
          s1_grp   <= grp_c;
          s1_tag   <= s_tag;
        end
      end
    end

    assign e_valid = s1_valid;
    assign e_carry = s1_carry;
    assign e_grp   = s1_grp;
    assign e_tag   = s1_tag;
  end else begin : g_comb
    assign e_valid = s_valid;
    assign e_carry = s_data[WIDTH-1];
    assign e_grp   = grp_c;
    assign e_tag   = s_tag;
  end

  logic [7:0] code_c;
  logic       shr_c;
  logic       zero_c;
  logic [5:0] shl_c;
  logic       any_nz;
  logic [5:0] lz_tot;

  always_comb begin
    any_nz = 1'b0;
    lz_tot = 6'd0;
    code_c = 8'h00;
    shr_c  = 1'b0;
    zero_c = 1'b0;
    shl_c  = 6'd0;
    // Descending scan so the most significant nonzero group wins.
    for (int g = NG - 1; g >= 0; g--) begin
      if (e_grp[g].nz) begin
        any_nz = 1'b1;
        lz_tot = 6'(g * GROUP_W) + 6'(e_grp[g].lz);
      end
    end
    if (e_carry) begin
      code_c = CODE_SHR1;
      shr_c  = 1'b1;
    end else if (!any_nz) begin
      code_c = CODE_ZERO;
      zero_c = 1'b1;
    end else begin
      shl_c  = lz_tot;
      code_c = {2'b00, lz_tot};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out   <= 1'b0;
      out_code    <= 8'h00;
      shift_right <= 1'b0;
      zero        <= 1'b0;
      shl_amt     <= 6'd0;
      tag_out     <= '0;
    end else begin
      valid_out <= e_valid & ~flush;
      if (e_valid && !flush) begin
        out_code    <= code_c;
        shift_right <= shr_c;
        zero        <= zero_c;
        shl_amt     <= shl_c;
        tag_out     <= e_tag;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_encoder.sv
// Randomised self-checking bench: four encoder configurations share one stimulus stream
// and are compared each cycle against an input-history reference model.
module tb_norm_shift_encoder;

`ifdef NORM_ENC_IN_REG_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  localparam int NI = 4;
  localparam int WS [NI] = '{49, 49, 25, 65};
  localparam int LS [NI] = '{1, 2, 1, 2};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic [64:0] in_data = '0;
  logic [7:0]  tag_in = '0;

  logic        vo [NI];
  logic [7:0]  oc [NI];
  logic        sr [NI];
  logic        zr [NI];
  logic [5:0]  sa [NI];
  logic [7:0]  tgo [NI];

  always #5 clk = ~clk;

  norm_shift_encoder #(.WIDTH(49), .LATENCY(1), .TAG_W(8)) u_w49_l1 (
    .clk(clk), .rstn(rstn), .flush(flush), .valid_in(valid_in), .in_data(in_data[48:0]),
    .tag_in(tag_in), .valid_out(vo[0]), .out_code(oc[0]), .shift_right(sr[0]), .zero(zr[0]),
    .shl_amt(sa[0]), .tag_out(tgo[0]));
  norm_shift_encoder #(.WIDTH(49), .LATENCY(2), .TAG_W(8)) u_w49_l2 (
    .clk(clk), .rstn(rstn), .flush(flush), .valid_in(valid_in), .in_data(in_data[48:0]),
    .tag_in(tag_in), .valid_out(vo[1]), .out_code(oc[1]), .shift_right(sr[1]), .zero(zr[1]),
    .shl_amt(sa[1]), .tag_out(tgo[1]));
  norm_shift_encoder #(.WIDTH(25), .LATENCY(1), .TAG_W(8)) u_w25_l1 (
    .clk(clk), .rstn(rstn), .flush(flush), .valid_in(valid_in), .in_data(in_data[24:0]),
    .tag_in(tag_in), .valid_out(vo[2]), .out_code(oc[2]), .shift_right(sr[2]), .zero(zr[2]),
    .shl_amt(sa[2]), .tag_out(tgo[2]));
  norm_shift_encoder #(.WIDTH(65), .LATENCY(2), .TAG_W(8)) u_w65_l2 (
    .clk(clk), .rstn(rstn), .flush(flush), .valid_in(valid_in), .in_data(in_data),
    .tag_in(tag_in), .valid_out(vo[3]), .out_code(oc[3]), .shift_right(sr[3]), .zero(zr[3]),
    .shl_amt(sa[3]), .tag_out(tgo[3]));

  typedef struct {
    logic        v;
    logic [64:0] d;
    logic [7:0]  t;
    logic        fl;
  } ent_t;

  ent_t        hist [$];
  logic [23:0] hold [NI];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", name, obs, exp, $time);
    end
  endtask

  // Highest-set-bit rule applied directly to the operand value.
  function automatic logic [7:0] ref_code(input int w, input logic [64:0] d);
    int h;
    h = -1;
    for (int i = 0; i < w; i++) if (d[i]) h = i;
    if (h < 0) return 8'h40;
    if (h == w - 1) return 8'h80;
    return 8'(w - 2 - h);
  endfunction

  function automatic logic [23:0] ref_pack(input int w, input logic [64:0] d, input logic [7:0] t);
    logic [64:0] m;
    logic [7:0]  c;
    m = (65'd1 << w) - 65'd1;
    if (w >= 65) m = '1;
    c = ref_code(w, d & m);
    return {c, (c == 8'h80), (c == 8'h40), ((c[7:6] == 2'b00) ? c[5:0] : 6'd0), t};
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int   l;
      logic ev;
      l  = LS[i] + EXT;
      ev = 1'b0;
      if (hist.size() >= l) begin
        ev = hist[hist.size() - l].v;
        for (int j = 1; j <= l; j++) if (hist[hist.size() - j].fl) ev = 1'b0;
        if (ev) hold[i] = ref_pack(WS[i], hist[hist.size() - l].d, hist[hist.size() - l].t);
      end
      chk($sformatf("inst%0d_valid_out", i), 32'(vo[i]), 32'(ev));
      chk($sformatf("inst%0d_result", i), 32'({oc[i], sr[i], zr[i], sa[i], tgo[i]}), 32'(hold[i]));
    end
  endtask

  task automatic step(input logic v, input logic [64:0] d, input logic [7:0] t, input logic fl);
    valid_in = v;
    in_data  = d;
    tag_in   = t;
    flush    = fl;
    @(posedge clk);
    hist.push_back('{v: v, d: d, t: t, fl: fl});
    if (hist.size() > 6) void'(hist.pop_front());
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    valid_in = 1'b0;
    flush    = 1'b0;
    hist.delete();
    for (int i = 0; i < NI; i++) hold[i] = '0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rstn = 1'b1;
  endtask

  function automatic logic [64:0] rand_operand();
    logic [95:0] r;
    logic [64:0] d;
    int          h;
    r = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 9) == 0) return '0;
    h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 64));
    d = r[64:0] & ((65'd1 << h) - 65'd1);
    d[h] = 1'b1;
    return d;
  endfunction

  initial begin
    for (int i = 0; i < NI; i++) hold[i] = '0;
    @(negedge clk);
    do_reset();

    step(1'b1, 65'h1_0000_0000_0000, 8'h5A, 1'b0);
    step(1'b1, 65'h0_0000_0000_0001, 8'h11, 1'b0);
    step(1'b1, 65'h0_8000_0000_0003, 8'h22, 1'b0);
    step(1'b1, 65'h0, 8'h33, 1'b0);
    idle(3);
    step(1'b1, 65'h0_800_000, 8'h44, 1'b0);
    step(1'b1, 65'h1_000_000, 8'h55, 1'b0);
    idle(3);

    for (int k = 0; k <= 47; k++) begin
      idle(int'($urandom_range(0, 2)));
      step(1'b1, 65'd1 << k, 8'(k), 1'b0);
    end
    idle(4);

    step(1'b1, 65'h0_0000_0001_0000, 8'hA1, 1'b0);
    step(1'b1, 65'h0_0400_0000_0000, 8'hA2, 1'b0);
    step(1'b0, '0, 8'h00, 1'b1);
    step(1'b1, 65'h0_0000_0000_0100, 8'hA3, 1'b0);
    idle(4);

    step(1'b1, 65'h0_0000_0020_0000, 8'hB1, 1'b0);
    step(1'b1, 65'h1_0000_0000_0000, 8'hB2, 1'b0);
    do_reset();
    idle(1);
    step(1'b1, 65'h0_0000_0000_0003, 8'hB3, 1'b0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), rand_operand(), 8'($urandom),
           ($urandom_range(0, 19) == 0));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
